pwm_sar_adc_mc: RTL and testbench

Multi-channel successor to the single-channel PWM/RC successive-approximation ADC. One PWM DAC (RC-filtered) is shared by NUM_CH comparators, one per analog input. The block scans the channels enabled in a mask, runs 2^AVG_LOG2 SAR conversions per channel, and emits one averaged code per channel through a valid-pulse result port. Single-shot and continuous scan modes are supported; it feeds the system control/readout logic.

---
 rtl/pwm_sar_adc_mc_pkg.sv | 24 ++
 rtl/pwm_sar_adc_mc_if.sv | 30 +++
 rtl/pwm_sar_adc_mc_dac.sv | 24 ++
 rtl/pwm_sar_adc_mc.sv | 176 +++++++++++++++++
 tb/tb_pwm_sar_adc_mc.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_sar_adc_mc_pkg.sv
// Shared types and sizing helpers for the multi-channel PWM/RC SAR ADC.
// Pure declarations: no latency, no flow control.
package pwm_sar_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      BIT,
      FINISH,
      EMIT,
      DONE
   } state_t;

   // Index width that never collapses to zero bits for one-entry ranges.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Accumulator width that holds 2^avg_log2 full-scale codes without overflow.
   function automatic int acc_w(input int width, input int avg_log2);
      return width + avg_log2;
   endfunction

endpackage

// File: rtl/pwm_sar_adc_mc_if.sv
// Scan control and sample result bundle between the ADC and its consumer.
// Result port is valid-pulse only: the consumer must accept every sample_valid.
interface pwm_sar_adc_mc_if #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8
);
   import pwm_sar_pkg::*;

   localparam int CH_W = clog2_min1(NUM_CH);

   logic              start;
   logic              continuous;
   logic [NUM_CH-1:0] ch_mask;
   logic              busy;
   logic              sample_valid;
   logic [CH_W-1:0]   sample_ch;
   logic [WIDTH-1:0]  sample_code;
   logic              scan_done;

   modport master (
      output start, continuous, ch_mask,
      input  busy, sample_valid, sample_ch, sample_code, scan_done
   );

   modport slave (
      input  start, continuous, ch_mask,
      output busy, sample_valid, sample_ch, sample_code, scan_done
   );

endinterface

// File: rtl/pwm_sar_adc_mc_dac.sv
// Free-running PWM DAC: pwm_out high while counter < duty, one register of latency.
// No flow control; duty may change on any cycle.
module pwm_dac #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] duty,
   output logic             pwm_out
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         pwm_out <= 1'b0;
      end else begin
         cnt     <= cnt + 1'b1;
         pwm_out <= (cnt < duty);
      end
   end

endmodule

// File: rtl/pwm_sar_adc_mc.sv
// Scans masked channels through one shared PWM DAC, averaging 2^AVG_LOG2 SAR conversions each.
// Per channel 2 + 2^AVG_LOG2*(WIDTH*SETTLE_CYCLES+1) cycles; start ignored while busy, no result backpressure.
module pwm_sar_adc_mc #(
   parameter int WIDTH         = 8,
   parameter int NUM_CH        = 4,
   parameter int SETTLE_CYCLES = 50000,
   parameter int AVG_LOG2      = 2
) (
   input  logic              clk,
   input  logic              reset,
   pwm_sar_adc_mc_if.slave   bus,
   input  logic [NUM_CH-1:0] comp_in,
   output logic              pwm_out
);
   import pwm_sar_pkg::*;

   localparam int CH_W  = clog2_min1(NUM_CH);
   localparam int ACC_W = acc_w(WIDTH, AVG_LOG2);
   localparam int BIT_W = clog2_min1(WIDTH);
   localparam int SET_W = clog2_min1(SETTLE_CYCLES);
   localparam int CNT_W = (AVG_LOG2 < 1) ? 1 : AVG_LOG2;

   localparam logic [WIDTH-1:0] MSB_ONLY    = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [BIT_W-1:0] TOP_BIT     = BIT_W'(WIDTH - 1);
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'((1 << AVG_LOG2) - 1);

   state_t            state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic              cont_q, cont_d;
   logic [WIDTH-1:0]  trial_code, trial_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [SET_W-1:0]  settle_q, settle_d;
   logic [CNT_W-1:0]  conv_q, conv_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [WIDTH-1:0]  code_q, code_d;
   logic [CH_W-1:0]   samp_ch_q, samp_ch_d;

   logic              sel_found;
   logic [CH_W-1:0]   sel_ch;
   logic [ACC_W-1:0]  sum;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         ch_q       <= '0;
         pending_q  <= '0;
         cont_q     <= 1'b0;
         trial_code <= '0;
         bit_q      <= '0;
         settle_q   <= '0;
         conv_q     <= '0;
         acc_q      <= '0;
         code_q     <= '0;
         samp_ch_q  <= '0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         pending_q  <= pending_d;
         cont_q     <= cont_d;
         trial_code <= trial_d;
         bit_q      <= bit_d;
         settle_q   <= settle_d;
         conv_q     <= conv_d;
         acc_q      <= acc_d;
         code_q     <= code_d;
         samp_ch_q  <= samp_ch_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      pending_d = pending_q;
      cont_d    = cont_q;
      trial_d   = trial_code;
      bit_d     = bit_q;
      settle_d  = settle_q;
      conv_d    = conv_q;
      acc_d     = acc_q;
      code_d    = code_q;
      samp_ch_d = samp_ch_q;

      // Descending scan so the lowest pending index wins.
      sel_found = 1'b0;
      sel_ch    = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            sel_found = 1'b1;
            sel_ch    = CH_W'(i);
         end
      end

      sum = acc_q + ACC_W'(trial_code);

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               pending_d = bus.ch_mask;
               cont_d    = bus.continuous;
               state_d   = SELECT;
            end
         end
         SELECT: begin
            if (sel_found) begin
               ch_d     = sel_ch;
               acc_d    = '0;
               conv_d   = '0;
               trial_d  = MSB_ONLY;
               bit_d    = TOP_BIT;
               settle_d = '0;
               state_d  = BIT;
            end else begin
               state_d  = DONE;
            end
         end
         BIT: begin
            if (settle_q == SETTLE_LAST) begin
               settle_d       = '0;
               trial_d[bit_q] = comp_in[ch_q];
               if (bit_q == '0) begin
                  state_d = FINISH;
               end else begin
                  trial_d[bit_q - 1'b1] = 1'b1;
                  bit_d                 = bit_q - 1'b1;
               end
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         FINISH: begin
            acc_d = sum;
            if (conv_q != CONV_LAST) begin
               conv_d   = conv_q + 1'b1;
               trial_d  = MSB_ONLY;
               bit_d    = TOP_BIT;
               settle_d = '0;
               state_d  = BIT;
            end else begin
               // Result registers load here so they are already valid during EMIT.
               code_d    = WIDTH'(sum >> AVG_LOG2);
               samp_ch_d = ch_q;
               state_d   = EMIT;
            end
         end
         EMIT: begin
            pending_d[ch_q] = 1'b0;
            state_d         = SELECT;
         end
         DONE: begin
            if (cont_q && bus.continuous) begin
               pending_d = bus.ch_mask;
               state_d   = SELECT;
            end else begin
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy         = (state_q != IDLE);
   assign bus.sample_valid = (state_q == EMIT);
   assign bus.scan_done    = (state_q == DONE);
   assign bus.sample_ch    = samp_ch_q;
   assign bus.sample_code  = code_q;

   pwm_dac #(.WIDTH(WIDTH)) u_dac (
      .clk     (clk),
      .reset   (reset),
      .duty    (trial_code),
      .pwm_out (pwm_out)
   );

endmodule

// File: tb/tb_pwm_sar_adc_mc.sv
// Bench for pwm_sar_adc_mc: ideal comparators, scoreboard of expected samples, table of scan vectors.
module tb_pwm_sar_adc_mc;
   import pwm_sar_pkg::*;

   localparam int WIDTH   = 8;
   localparam int NUM_CH  = 4;
   localparam int SETTLE  = 4;
   localparam int AVG     = 2;
   localparam int CONV    = WIDTH * SETTLE + 1;
   localparam int CH_LAT  = 1 + (1 << AVG) * CONV + 1;

   logic              clk = 1'b0;
   logic              reset;
   logic [NUM_CH-1:0] comp_in;
   logic              pwm_out;
   logic [7:0]        vin [NUM_CH];

   always #5 clk = ~clk;

   pwm_sar_adc_mc_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

   pwm_sar_adc_mc #(
      .WIDTH(WIDTH), .NUM_CH(NUM_CH), .SETTLE_CYCLES(SETTLE), .AVG_LOG2(AVG)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus.slave),
      .comp_in (comp_in),
      .pwm_out (pwm_out)
   );

   // Ideal comparator: input voltage at or above the DAC level.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_cmp
      assign comp_in[g] = (vin[g] >= dut.trial_code);
   end

   typedef struct {
      logic [1:0] ch;
      logic [7:0] code;
   } exp_t;

   typedef struct {
      logic [3:0]  mask;
      logic [31:0] vins;   // vin3..vin0, one byte each
      int          n_exp;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   sv_seen = 0;
   int   last_sv = -1;
   bit   chk_spacing = 1'b1;
   vec_t tbl[5];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_exp(input int ch, input logic [7:0] code);
      exp_t e;
      e.ch   = 2'(ch);
      e.code = code;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (bus.sample_valid === 1'b1) begin
         sv_seen++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sample: ch=%0d code=%0h arrived with nothing expected", bus.sample_ch, bus.sample_code);
         end else begin
            mon_e = sb.pop_front();
            check("sample_ch", 32'(bus.sample_ch), 32'(mon_e.ch));
            check("sample_code", 32'(bus.sample_code), 32'(mon_e.code));
         end
         if (chk_spacing && last_sv >= 0) check("sample_spacing", cyc - last_sv, CH_LAT);
         last_sv = cyc;
      end
   end

   // Drive start for one cycle; returns at the following negedge (first busy cycle).
   task automatic pulse_start(output int at);
      bus.start = 1'b1;
      at = cyc;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int limit, input string name, output int when, output bit ok);
      ok = 1'b0;
      when = -1;
      for (int k = 0; k < limit; k++) begin
         if (bus.scan_done === 1'b1) begin
            ok = 1'b1;
            when = cyc;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s: scan_done not seen within %0d cycles", name, limit);
      end
   endtask

   task automatic run_vector(input vec_t t, input string tag);
      int s, d, sv0;
      bit ok;
      for (int i = 0; i < NUM_CH; i++) vin[i] = t.vins[8*i +: 8];
      bus.ch_mask = t.mask;
      for (int i = 0; i < NUM_CH; i++) if (t.mask[i]) push_exp(i, t.vins[8*i +: 8]);
      sv0 = sv_seen;
      last_sv = -1;
      pulse_start(s);
      check({tag, "_busy_after_start"}, 32'(bus.busy), 1);
      wait_done(NUM_CH * CH_LAT + 20, {tag, "_done"}, d, ok);
      if (ok) check({tag, "_done_cycle"}, d - s, t.n_exp * CH_LAT + 2);
      @(negedge clk);
      check({tag, "_busy_low"}, 32'(bus.busy), 0);
      check({tag, "_sample_count"}, sv_seen - sv0, t.n_exp);
      check({tag, "_sb_empty"}, sb.size(), 0);
      sb.delete();
   endtask

   initial begin : main
      int s, d1, d2, d3, sv0, hi;
      bit ok;

      tbl[0] = '{mask: 4'b1111, vins: 32'h80FF5A00, n_exp: 4};
      tbl[1] = '{mask: 4'b1001, vins: 32'h112233C7, n_exp: 2};
      tbl[2] = '{mask: 4'b0000, vins: 32'h55555555, n_exp: 0};
      tbl[3] = '{mask: 4'b0010, vins: 32'h00000100, n_exp: 1};
      tbl[4] = '{mask: 4'b0110, vins: 32'h007FFE00, n_exp: 2};

      reset = 1'b1;
      bus.start = 1'b0;
      bus.continuous = 1'b0;
      bus.ch_mask = '0;
      for (int i = 0; i < NUM_CH; i++) vin[i] = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check("rst_busy", 32'(bus.busy), 0);
      check("rst_sample_valid", 32'(bus.sample_valid), 0);
      check("rst_sample_ch", 32'(bus.sample_ch), 0);
      check("rst_sample_code", 32'(bus.sample_code), 0);
      check("rst_scan_done", 32'(bus.scan_done), 0);
      hi = 0;
      repeat (256) begin
         @(negedge clk);
         if (pwm_out) hi++;
      end
      check("pwm_duty_zero", hi, 0);

      for (int v = 0; v < 5; v++) run_vector(tbl[v], $sformatf("vec%0d", v));

      // Averaging: vin[1] alternates between conversions, changed during each FINISH cycle.
      vin[1] = 8'h40;
      bus.ch_mask = 4'b0010;
      push_exp(1, 8'h41);
      last_sv = -1;
      pulse_start(s);
      for (int k = 0; k < 3; k++) begin
         repeat (CONV) @(negedge clk);
         vin[1] = (k % 2 == 0) ? 8'h43 : 8'h40;
      end
      wait_done(2 * CH_LAT, "avg_done", d1, ok);
      @(negedge clk);
      check("avg_busy_low", 32'(bus.busy), 0);
      check("avg_sb_empty", sb.size(), 0);
      sb.delete();

      // start while busy must not restart or extend the scan.
      vin[0] = 8'h40;
      bus.ch_mask = 4'b0001;
      push_exp(0, 8'h40);
      last_sv = -1;
      sv0 = sv_seen;
      pulse_start(s);
      repeat (50) @(negedge clk);
      bus.ch_mask = 4'b1111;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(2 * CH_LAT, "busy_start_done", d1, ok);
      if (ok) check("busy_start_done_cycle", d1 - s, CH_LAT + 2);
      repeat (300) @(negedge clk);
      check("busy_start_idle", 32'(bus.busy), 0);
      check("busy_start_count", sv_seen - sv0, 1);
      sb.delete();

      // Trial code stays at the last result (0x40) while idle.
      hi = 0;
      repeat (256) begin
         @(negedge clk);
         if (pwm_out) hi++;
      end
      check("pwm_duty_0x40", hi, 64);

      // Continuous mode: three passes, dropping continuous during the third.
      chk_spacing = 1'b0;
      vin[2] = 8'h37;
      bus.ch_mask = 4'b0100;
      bus.continuous = 1'b1;
      for (int k = 0; k < 3; k++) push_exp(2, 8'h37);
      pulse_start(s);
      wait_done(2 * CH_LAT, "cont_done1", d1, ok);
      if (ok) check("cont_done1_cycle", d1 - s, CH_LAT + 2);
      @(negedge clk);
      check("cont_busy_kept", 32'(bus.busy), 1);
      wait_done(2 * CH_LAT, "cont_done2", d2, ok);
      if (ok) check("cont_pass_len", d2 - d1, CH_LAT + 2);
      @(negedge clk);
      bus.continuous = 1'b0;
      wait_done(2 * CH_LAT, "cont_done3", d3, ok);
      @(negedge clk);
      check("cont_busy_low", 32'(bus.busy), 0);
      check("cont_sb_empty", sb.size(), 0);
      sb.delete();
      chk_spacing = 1'b1;

      // Reset in the middle of channel 1's first BIT phase.
      vin[0] = 8'h9C; vin[1] = 8'h20; vin[2] = 8'h30; vin[3] = 8'h10;
      bus.ch_mask = 4'b1111;
      push_exp(0, 8'h9C);
      last_sv = -1;
      pulse_start(s);
      repeat (149) @(negedge clk);
      check("hold_code_before_reset", 32'(bus.sample_code), 32'h9C);
      check("busy_before_reset", 32'(bus.busy), 1);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_busy", 32'(bus.busy), 0);
      check("midrst_sample_valid", 32'(bus.sample_valid), 0);
      check("midrst_sample_ch", 32'(bus.sample_ch), 0);
      check("midrst_sample_code", 32'(bus.sample_code), 0);
      check("midrst_scan_done", 32'(bus.scan_done), 0);
      check("midrst_pwm_out", 32'(pwm_out), 0);
      reset = 1'b0;
      sv0 = sv_seen;
      repeat (300) @(negedge clk);
      check("midrst_no_sample", sv_seen - sv0, 0);
      check("midrst_idle", 32'(bus.busy), 0);
      check("midrst_sb_empty", sb.size(), 0);
      sb.delete();

      run_vector(tbl[0], "post_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
